uvmt_cv32e40s_debug_req_chk: RTL
================================

# uvmt_cv32e40s_debug_req_chk

Parametrised, multi-channel debug-request protocol checker for the CV32E40S testbench, the synthesizable successor to the DUT-level checker. Each channel observes one core's debug request and debug-mode status, tracks the request-to-entry handshake with a per-channel FSM, measures entry latency, and flags timeouts and spurious debug entries. It sits in uvmt alongside the DUT wrapper. It is driven from the debug agent interface signals and reports to scoreboard or assertion logic.

## Interface
- NUM_CHANNELS, 1: number of independent harts/channels observed.
- TIMEOUT_CYCLES, 64: maximum legal request-to-entry latency in cycles; must be ≥1.
- CNT_W, 8: counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

- clk_i  in  1  clock; one clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- debug_req_i  in  NUM_CHANNELS  debug request per channel. May be a level or a single-cycle pulse.
- debug_mode_i  in  NUM_CHANNELS  core is in debug mode, per channel.
- latency_valid_o  out  NUM_CHANNELS  one-cycle pulse: latency_o slice valid.
- latency_o  out  NUM_CHANNELS*CNT_W  last measured entry latency, channel c at [c*CNT_W +: CNT_W].
- entry_cnt_o  out  NUM_CHANNELS*CNT_W  debug entries per channel, saturating.
- err_timeout_o  out  NUM_CHANNELS  one-cycle pulse on latency timeout.
- err_spurious_o  out  NUM_CHANNELS  one-cycle pulse on debug entry without request.
- err_any_o  out  1  sticky OR of all error pulses; cleared only by reset.

## Operation
- Each channel has an independent FSM with states IDLE, PENDING, TIMEOUT, IN_DEBUG, plus a latency counter cnt[CNT_W].
- IDLE:
  - If req=1 and mode=1: legal zero-latency entry. Report latency 0 and go to IN_DEBUG.
  - If req=1 and mode=0: cnt←1 and go to PENDING.
  - If req=0 and mode=1: pulse err_spurious and go to IN_DEBUG. No latency is reported.
- PENDING:
  - If mode=1: report latency_o←cnt and go to IN_DEBUG.
  - Else if cnt==TIMEOUT_CYCLES: pulse err_timeout and go to TIMEOUT.
  - Else cnt←cnt+1.
  - Deassertion of req in PENDING is legal, because the core latches the request; the channel stays PENDING.
- TIMEOUT: stay until mode=1, then go to IN_DEBUG with no latency report. Repeated timeout pulses are forbidden.
- IN_DEBUG: when mode=0, go to PENDING (cnt←1) if req=1, else go to IDLE. Requests while in debug mode are ignored.
- Every transition into IN_DEBUG increments entry_cnt for that channel, saturating at 2**CNT_W-1.
- err_any_o is set on any err_timeout or err_spurious pulse on any channel.

## Timing
- All outputs are registered. A pulse appears in the cycle after the sampling edge of the triggering event and lasts exactly one cycle.
- Latency definition: req first sampled high at edge t (from IDLE), mode first sampled high at edge t+k gives latency_o=k. The legal range is 0..TIMEOUT_CYCLES.
- Timeout timing: err_timeout asserts one cycle after edge t+TIMEOUT_CYCLES, when mode is still low at that edge.
- latency_o holds its last value until the next report.
- Reset values: FSM=IDLE, cnt=0, latency_o=0, entry_cnt_o=0; all pulses and err_any_o are 0.
- Reset mid-operation: rst_i wins over every transition. No pulse is emitted in the cycle following a reset edge.
- Channels never interact, except through the OR into err_any_o. Simultaneous events on different channels are reported in the same cycle.

## Configuration
- UVMT_CV32E40S_DEBUG_CHK_SPURIOUS_EN
  - Defined: spurious-entry detection is active as described.
  - Undefined:
    - IDLE with mode=1 goes to IN_DEBUG silently and still increments entry_cnt.
    - err_spurious_o is tied to 0 and does not feed err_any_o.

## Test plan
- NUM_CHANNELS=2, TIMEOUT_CYCLES=64. Pulse req0 for 1 cycle, raise mode0 5 cycles later → latency_valid_o[0] pulses with latency_o[7:0]=5, entry_cnt_o[7:0]=1; channel 1 stays silent.
- Assert req and mode in the same cycle → latency_o=0 and no error.
- Hold req, keep mode low for 70 cycles → err_timeout_o pulses once, one cycle after edge t+64, and err_any_o=1. Then raise mode → no latency pulse, entry_cnt increments.
- Raise mode with no request, macro defined → err_spurious_o=1 for one cycle, err_any_o=1. Same stimulus with macro undefined → no error, entry_cnt=1.
- Drive 300 legal entries → entry_cnt_o saturates at 255.
- Assert rst_i while PENDING at cnt=30 → all outputs are 0 next cycle, and the next request measures latency from scratch.

Source files
------------

// File: rtl/uvmt_cv32e40s_debug_req_chk.sv
// ============================================================================
// Module      : uvmt_cv32e40s_debug_req_chk
// Description : Multi-channel debug-request checker. Tracks the request-to-
//               entry handshake, measures entry latency, and flags timeouts
//               and (with UVMT_CV32E40S_DEBUG_CHK_SPURIOUS_EN) spurious entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uvmt_cv32e40s_debug_req_chk #(
  parameter int NUM_CHANNELS   = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CHANNELS-1:0]       debug_req_i,
  input  logic [NUM_CHANNELS-1:0]       debug_mode_i,
  output logic [NUM_CHANNELS-1:0]       latency_valid_o,
  output logic [NUM_CHANNELS*CNT_W-1:0] latency_o,
  output logic [NUM_CHANNELS*CNT_W-1:0] entry_cnt_o,
  output logic [NUM_CHANNELS-1:0]       err_timeout_o,
  output logic [NUM_CHANNELS-1:0]       err_spurious_o,
  output logic                          err_any_o
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_SAT     = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    TIMEOUT  = 2'd2,
    IN_DEBUG = 2'd3
  } state_t;

  logic [NUM_CHANNELS-1:0] w_to_next;
  logic [NUM_CHANNELS-1:0] w_sp_next;
  logic                    r_err_any;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_lat, w_lat_next;
    logic [CNT_W-1:0] r_entry;
    logic             r_lat_vld, w_lat_vld_next;
    logic             r_to;
    logic             w_enter;
    logic             w_req, w_mode;

    assign w_req  = debug_req_i[c];
    assign w_mode = debug_mode_i[c];

    always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_lat_next     = r_lat;
      w_lat_vld_next = 1'b0;
      w_to_next[c]   = 1'b0;
      w_sp_next[c]   = 1'b0;
      w_enter        = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req && w_mode) begin
            w_lat_next     = '0;
            w_lat_vld_next = 1'b1;
            w_enter        = 1'b1;
            w_state_next   = IN_DEBUG;
          end else if (w_req) begin
            w_cnt_next   = C_ONE;
            w_state_next = PENDING;
          end else if (w_mode) begin
`ifdef UVMT_CV32E40S_DEBUG_CHK_SPURIOUS_EN
            w_sp_next[c] = 1'b1;
`endif
            w_enter      = 1'b1;
            w_state_next = IN_DEBUG;
          end
        end
        PENDING: begin
          // Request deassertion is ignored here: the core has latched it.
          if (w_mode) begin
            w_lat_next     = r_cnt;
            w_lat_vld_next = 1'b1;
            w_enter        = 1'b1;
            w_state_next   = IN_DEBUG;
          end else if (r_cnt == C_TIMEOUT) begin
            w_to_next[c] = 1'b1;
            w_state_next = TIMEOUT;
          end else begin
            w_cnt_next = r_cnt + C_ONE;
          end
        end
        TIMEOUT: begin
          if (w_mode) begin
            w_enter      = 1'b1;
            w_state_next = IN_DEBUG;
          end
        end
        IN_DEBUG: begin
          if (!w_mode) begin
            if (w_req) begin
              w_cnt_next   = C_ONE;
              w_state_next = PENDING;
            end else begin
              w_state_next = IDLE;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_lat     <= '0;
        r_lat_vld <= 1'b0;
        r_to      <= 1'b0;
        r_entry   <= '0;
      end else begin
        r_state   <= w_state_next;
        r_cnt     <= w_cnt_next;
        r_lat     <= w_lat_next;
        r_lat_vld <= w_lat_vld_next;
        r_to      <= w_to_next[c];
        if (w_enter && (r_entry != C_SAT)) begin
          r_entry <= r_entry + C_ONE;
        end
      end
    end

    assign latency_valid_o[c]             = r_lat_vld;
    assign latency_o[c*CNT_W +: CNT_W]    = r_lat;
    assign entry_cnt_o[c*CNT_W +: CNT_W]  = r_entry;
    assign err_timeout_o[c]               = r_to;

`ifdef UVMT_CV32E40S_DEBUG_CHK_SPURIOUS_EN
    logic r_sp;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sp <= 1'b0;
      end else begin
        r_sp <= w_sp_next[c];
      end
    end
    assign err_spurious_o[c] = r_sp;
`else
    assign err_spurious_o[c] = 1'b0;
`endif
  end

  // Sticky flag is set alongside the pulse so both are visible in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_any <= 1'b0;
    end else if ((|w_to_next) || (|w_sp_next)) begin
      r_err_any <= 1'b1;
    end
  end

  assign err_any_o = r_err_any;

endmodule

`default_nettype wire
